bus_mem_responder: RTL and testbench

Bus responder for the CPU's data bus: it decodes ADDR/CS/WR, stores writes into an internal word RAM and returns registered read data on Data_BUS_READ. It sits at the other end of the cpu bus (cpu = initiator, this block = responder) and replaces stimulus-driven Data_BUS_READ in system-level benches. After every reset it clears its RAM with a hardware sweep, signals BUSY while doing so, and flags illegal (out-of-window) accesses.

---
 rtl/bus_mem_responder.sv | 106 ++++++++++
 tb/tb_bus_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Data-bus responder backed by a word RAM.
// Clears its RAM after reset; flags out-of-window accesses.
module bus_mem_responder #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] ADDR,
  input  logic        CS,
  input  logic        WR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        BUSY,
  output logic        ERR,
  output logic [15:0] ACC_CNT
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic              in_win;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              acc_ok;
  logic              err_set;
  logic              rd_req;

  assign idx    = ADDR[ADDR_W+1:2];
  assign in_win = ADDR[31:ADDR_W+2] == BASE[31:ADDR_W+2];
  assign rd_req = CS && !WR;
  assign BUSY   = state == CLEAR;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = Data_BUS_WRITE;
    acc_ok    = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = '0;
        if (clr_ptr == LAST) state_nxt = READY;
      end
      READY: begin
        if (CS) begin
          if (in_win) begin
            acc_ok = 1'b1;
            mem_we = WR;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Pointer parks on the last index once the sweep is done.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      clr_ptr <= '0;
    end else if (state == CLEAR && clr_ptr != LAST) begin
      clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      Data_BUS_READ <= '0;
    end else if (rd_req) begin
      if (acc_ok) Data_BUS_READ <= mem[idx];
      else        Data_BUS_READ <= '0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ERR     <= 1'b0;
      ACC_CNT <= '0;
    end else begin
      if (err_set) ERR <= 1'b1;
      if (acc_ok && ACC_CNT != 16'hFFFF) ACC_CNT <= ACC_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder.
// Read data is checked by a monitor against a queue of expectations.
module tb_bus_mem_responder;

  logic        CLK;
  logic        rst;
  logic [31:0] ADDR;
  logic        CS;
  logic        WR;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;
  logic        BUSY;
  logic        ERR;
  logic [15:0] ACC_CNT;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bus_mem_responder #(.ADDR_W(10), .BASE(32'h0)) dut (
    .CLK            (CLK),
    .rst            (rst),
    .ADDR           (ADDR),
    .CS             (CS),
    .WR             (WR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
    .BUSY           (BUSY),
    .ERR            (ERR),
    .ACC_CNT        (ACC_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read sampled at an edge presents data just after it.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge CLK);
      if (rst && CS && !WR) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %h, expected no read", Data_BUS_READ);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", Data_BUS_READ, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    CS = 1'b0;
    WR = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    CS = 1'b1;
    WR = 1'b1;
    ADDR = a;
    Data_BUS_WRITE = d;
    @(posedge CLK);
    #1;
    CS = 1'b0;
    WR = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    CS = 1'b1;
    WR = 1'b0;
    ADDR = a;
    @(posedge CLK);
    #1;
    CS = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, Data_BUS_READ, 32'h0);
    chk({tag, "_busy"}, {31'b0, BUSY}, 32'h1);
    chk({tag, "_err"}, {31'b0, ERR}, 32'h0);
    chk({tag, "_cnt"}, {16'b0, ACC_CNT}, 32'h0);
  endtask

  // Releases reset on a falling edge and counts rising edges with BUSY high.
  // Optionally drives accesses during the sweep that must be ignored.
  task automatic sweep(input bit poke, output int n);
    @(negedge CLK);
    rst = 1'b1;
    n = 0;
    while (BUSY && n < 3000) begin
      CS = 1'b0;
      WR = 1'b0;
      if (poke) begin
        case (n)
          2: begin
            CS = 1'b1; WR = 1'b1;
            ADDR = 32'h14; Data_BUS_WRITE = 32'h1234_5678;
          end
          3: begin
            CS = 1'b1; WR = 1'b0; ADDR = 32'h14;
            exp_q.push_back(32'h0);
          end
          4: begin
            CS = 1'b1; WR = 1'b1;
            ADDR = 32'h1000; Data_BUS_WRITE = 32'hFFFF_FFFF;
          end
          default: ;
        endcase
      end
      @(posedge CLK);
      #1;
      n++;
    end
    CS = 1'b0;
    WR = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    CS = 1'b0;
    WR = 1'b0;
    ADDR = '0;
    Data_BUS_WRITE = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("rst0");

    sweep(1'b1, n);
    chk("busy_len1", n, 1024);
    chk("sweep_err", {31'b0, ERR}, 32'h0);
    chk("sweep_cnt", {16'b0, ACC_CNT}, 32'h0);

    bus_rd(32'h14, 32'h0);
    bus_rd(32'h0, 32'h0);
    bus_rd(32'hFFC, 32'h0);
    bus_wr(32'h10, 32'hDEAD_BEEF);
    bus_rd(32'h10, 32'hDEAD_BEEF);
    bus_rd(32'h13, 32'hDEAD_BEEF);
    chk("cnt_wr_rd", {16'b0, ACC_CNT}, 32'd6);
    idle(3);
    chk("rd_hold", Data_BUS_READ, 32'hDEAD_BEEF);

    bus_wr(32'h20, 32'h1111_2222);
    bus_wr(32'h24, 32'h3333_4444);
    bus_rd(32'h24, 32'h3333_4444);
    bus_rd(32'h20, 32'h1111_2222);
    chk("cnt_b2b", {16'b0, ACC_CNT}, 32'd10);
    chk("err_clean", {31'b0, ERR}, 32'h0);

    bus_wr(32'h1000, 32'hCAFE_F00D);
    chk("oow_err", {31'b0, ERR}, 32'h1);
    chk("oow_cnt", {16'b0, ACC_CNT}, 32'd10);
    bus_rd(32'h20, 32'h1111_2222);
    bus_rd(32'h1000, 32'h0);
    bus_rd(32'h0, 32'h0);
    bus_rd(32'hFFFF_FFFC, 32'h0);
    idle(4);
    chk("err_sticky", {31'b0, ERR}, 32'h1);
    chk("oow_cnt2", {16'b0, ACC_CNT}, 32'd12);

    bus_rd(32'h20, 32'h1111_2222);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_mid_op");
    sweep(1'b0, n);
    // second pass: reset again partway through the sweep
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    repeat (300) @(posedge CLK);
    #2;
    chk("mid_busy", {31'b0, BUSY}, 32'h1);
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_mid_sweep");
    sweep(1'b0, n);
    chk("busy_len2", n, 1024);
    bus_rd(32'h10, 32'h0);
    bus_rd(32'h20, 32'h0);
    chk("post_cnt", {16'b0, ACC_CNT}, 32'd2);

    bus_wr(32'h30, 32'h5A5A_5A5A);
    for (int i = 0; i < 65531; i++) bus_rd(32'h30, 32'h5A5A_5A5A);
    chk("cnt_fffe", {16'b0, ACC_CNT}, 32'h0000_FFFE);
    bus_rd(32'h30, 32'h5A5A_5A5A);
    chk("cnt_ffff", {16'b0, ACC_CNT}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) bus_rd(32'h34, 32'h0);
    bus_wr(32'h34, 32'h1);
    chk("cnt_sat", {16'b0, ACC_CNT}, 32'h0000_FFFF);
    bus_rd(32'h34, 32'h1);

    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
